ps2_host_tx: RTL and testbench

- Host-to-device PS/2 command transmitter: the outbound direction of the PS/2 port, alongside the existing inbound receive path.
- Sends one byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to a keyboard or mouse using the inhibit / request-to-send / device-clocked sequence, then checks the device's ack bit.
- Sits between a Nios-side command register or FIFO and the open-drain PS/2 pads; shares the pads with the receiver.

---
 rtl/ps2_host_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues request-to-send, shifts one byte plus
// odd parity on device-generated clock falls, then checks the ack bit.
// Optional ack timeout: define PS2_TX_TIMEOUT_EN.
// Ports:
//   clk_clk, reset_reset_n       : system clock, async active-low reset
//   tx_data/tx_valid/tx_ready    : byte request handshake
//   tx_done/tx_error             : one-cycle outcome pulses
//   tx_busy                      : transfer in progress (receiver ignores bus)
//   ps2_clk_i/ps2_dat_i          : asynchronous pad inputs
//   ps2_clk_oe/ps2_dat_oe        : 1 = pull the open-drain line low
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int INHIBIT_US  = 120,
  parameter int TIMEOUT_US  = 15000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       tx_busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CYC_US  = CLK_FREQ_HZ / 1000000;
  localparam int INH_CYC = CYC_US * INHIBIT_US;
  localparam int INH_W   = $clog2(INH_CYC);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);
  localparam int TMO_CYC = CYC_US * TIMEOUT_US;

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, ACK, WAIT_IDLE
  } state_t;

  state_t     state, state_n;
  logic [INH_W-1:0] cnt, cnt_n;
  logic [8:0] shreg, shreg_n;
  logic [3:0] bit_cnt, bit_n;
  logic       dat_oe, dat_oe_n;
  logic       ok, ok_n;
  logic       done_p, err_p;

  logic       clk_m, clk_s, dat_m, dat_s;
  logic       clk_f, clk_fd;
  logic [FLT_W-1:0] flt_cnt;
  logic       fall;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC);
  logic [TMO_W-1:0] tmo, tmo_n;
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CYC == 0);
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      clk_m   <= 1'b1;
      clk_s   <= 1'b1;
      dat_m   <= 1'b1;
      dat_s   <= 1'b1;
      clk_f   <= 1'b1;
      clk_fd  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_m  <= ps2_clk_i;
      clk_s  <= clk_m;
      dat_m  <= ps2_dat_i;
      dat_s  <= dat_m;
      clk_fd <= clk_f;
      if (clk_s == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        clk_f   <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_fd & ~clk_f;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      dat_oe  <= 1'b0;
      ok      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      tmo     <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_n;
      dat_oe  <= dat_oe_n;
      ok      <= ok_n;
`ifdef PS2_TX_TIMEOUT_EN
      tmo     <= tmo_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    bit_n    = bit_cnt;
    dat_oe_n = dat_oe;
    ok_n     = ok;
    done_p   = 1'b0;
    err_p    = 1'b0;
    unique case (state)
      IDLE: begin
        dat_oe_n = 1'b0;
        if (tx_valid) begin
          state_n = INHIBIT;
          cnt_n   = '0;
          shreg_n = {~^tx_data, tx_data};
          bit_n   = '0;
        end
      end
      INHIBIT: begin
        cnt_n = cnt + 1'b1;
        // start bit goes out during the last inhibit cycle
        if (cnt == INH_W'(INH_CYC - 2))
          dat_oe_n = 1'b1;
        if (cnt == INH_W'(INH_CYC - 1))
          state_n = RTS;
      end
      RTS: begin
        if (fall) begin
          bit_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) begin
            dat_oe_n = 1'b0;
            state_n  = ACK;
          end else begin
            dat_oe_n = ~shreg[0];
            shreg_n  = {1'b0, shreg[8:1]};
          end
        end
      end
      ACK: begin
        if (fall) begin
          ok_n    = ~dat_s;
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_f && dat_s) begin
          done_p  = ok;
          err_p   = ~ok;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    tmo_n = '0;
    if (state == RTS || state == ACK) begin
      tmo_n = tmo + 1'b1;
      if (tmo == TMO_W'(TMO_CYC - 1)) begin
        dat_oe_n = 1'b0;
        err_p    = 1'b1;
        state_n  = IDLE;
      end
    end
`endif
  end

  assign tx_ready   = (state == IDLE);
  assign tx_busy    = (state != IDLE);
  assign tx_done    = done_p;
  assign tx_error   = err_p;
  assign ps2_clk_oe = (state == INHIBIT);
  assign ps2_dat_oe = dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a PS/2 device model.
// Scaled clocking: 1 MHz nominal so inhibit = 60 cycles, timeout = 15000.
module tb_ps2_host_tx;

  localparam int N_INH = 60;
  localparam int HALF  = 40;
  localparam int TMO   = 15000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready, tx_done, tx_error, tx_busy;
  logic ps2_clk_oe, ps2_dat_oe;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic ps2_clk_i, ps2_dat_i;

  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .CLK_FREQ_HZ(1000000),
    .INHIBIT_US (60),
    .TIMEOUT_US (15000),
    .FILTER_LEN (8)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .tx_error     (tx_error),
    .tx_busy      (tx_busy),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_dat_i    (ps2_dat_i),
    .ps2_clk_oe   (ps2_clk_oe),
    .ps2_dat_oe   (ps2_dat_oe)
  );

  typedef struct packed {
    logic [10:0] frame;
    logic        ok;
    logic        chk;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic check_rng(input string nm, input int v,
                           input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      fails++;
      $display("FAIL %s: got %0d required %0d..%0d", nm, v, lo, hi);
    end
  endtask

  // Device model: receives a host frame, then acks (or not).
  logic dev_silent = 1'b0;
  logic dev_nack = 1'b0;
  int dev_falls = 0;
  logic [10:0] dev_frame = '0;

  initial begin : device
    logic [10:0] f;
    forever begin
      @(negedge clk);
      if (!dev_silent && rst_n && ps2_clk_i && !ps2_dat_i) begin
        f = '1;
        f[0] = ps2_dat_i;
        dev_falls = 0;
        for (int i = 1; i <= 10; i++) begin
          repeat (HALF) @(negedge clk);
          dev_clk = 1'b0;
          dev_falls++;
          repeat (HALF) @(negedge clk);
          f[i] = ps2_dat_i;
          dev_clk = 1'b1;
        end
        dev_frame = f;
        repeat (HALF / 2) @(negedge clk);
        if (!dev_nack) dev_dat = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_dat = 1'b1;
      end
    end
  end

  // Outcome monitor: every done/error pulse consumes one expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (tx_done || tx_error)) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_pulse: done=%b error=%b none pending",
                   tx_done, tx_error);
        end else begin
          e = exp_q.pop_front();
          check("outcome", {30'd0, tx_done, tx_error},
                e.ok ? 32'd2 : 32'd1);
          if (e.chk)
            check("frame", {21'd0, dev_frame}, {21'd0, e.frame});
        end
      end
    end
  end

  // Inhibit monitor: clock hold time and start bit at release.
  initial begin : inh_mon
    int inh;
    inh = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inh = 0;
      end else if (ps2_clk_oe) begin
        inh++;
      end else if (inh > 0) begin
        check_rng("inhibit_len", inh, N_INH, N_INH + 1);
        check("start_bit_at_release", {31'd0, ps2_dat_oe}, 32'd1);
        inh = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] b);
    int i;
    @(negedge clk);
    for (i = 0; i < 6000 && !tx_ready; i++) @(negedge clk);
    if (!tx_ready) begin
      checks++;
      fails++;
      $display("FAIL issue_ready: tx_ready=%b required 1", tx_ready);
    end
    tx_data = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic [10:0] fr,
                      input logic ok);
    exp_t e;
    e.frame = fr;
    e.ok = ok;
    e.chk = 1'b1;
    exp_q.push_back(e);
    issue(b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && tx_ready) return;
    end
    checks++;
    fails++;
    $display("FAIL wait_idle: pending=%0d ready=%b required 0/1",
             exp_q.size(), tx_ready);
  endtask

  initial begin : stim
    exp_t e;
    int n;
    tx_data = '0;
    tx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_outputs",
          {26'd0, tx_ready, tx_done, tx_error, tx_busy,
           ps2_clk_oe, ps2_dat_oe}, 32'b100000);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send(8'hED, 11'b1_1_11101101_0, 1'b1);
    wait_idle();
    send(8'hF4, 11'b1_0_11110100_0, 1'b1);
    wait_idle();
    send(8'h00, 11'b1_1_00000000_0, 1'b1);
    wait_idle();
    send(8'hFF, 11'b1_1_11111111_0, 1'b1);
    wait_idle();

    dev_nack = 1'b1;
    send(8'hFF, 11'b1_1_11111111_0, 1'b0);
    wait_idle();
    check("nack_released", {29'd0, ps2_clk_oe, ps2_dat_oe, tx_ready},
          32'b001);
    repeat (HALF) @(negedge clk);
    dev_nack = 1'b0;

    e.frame = 11'b1_1_11101101_0; e.ok = 1'b1; e.chk = 1'b1;
    exp_q.push_back(e);
    e.frame = 11'b1_1_01010101_0;
    exp_q.push_back(e);
    @(negedge clk);
    tx_data = 8'hED;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'h55;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (tx_ready) break;
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    wait_idle();

    issue(8'hED);
    for (int i = 0; i < 6000 && dev_falls != 4; i++) @(negedge clk);
    check("reached_fall4", dev_falls, 4);
    repeat (15) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("async_reset_ready", {30'd0, tx_ready, tx_busy}, 32'b10);
    repeat (1200) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send(8'hF4, 11'b1_0_11110100_0, 1'b1);
    wait_idle();

    dev_silent = 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
    e.frame = '0; e.ok = 1'b0; e.chk = 1'b0;
    exp_q.push_back(e);
`endif
    issue(8'hF4);
    for (int i = 0; i < 200 && ps2_clk_oe; i++) @(negedge clk);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!tx_error && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_rng("timeout_cycles", n, TMO - 2, TMO + 1);
    @(negedge clk);
    check("timeout_released",
          {29'd0, ps2_clk_oe, ps2_dat_oe, tx_ready}, 32'b001);
`else
    n = 0;
    repeat (20000) @(negedge clk);
    check("silent_stays_rts",
          {29'd0, tx_busy, ps2_clk_oe, ps2_dat_oe}, 32'b101);
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dev_silent = 1'b0;
    repeat (5) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
